// File: rtl/quad_decoder_multi_if.sv
// Pin-side and control-side bundle for the multi-channel quadrature decoder.
// The slave modport is the decoder; the master modport is the board/game side.
interface quad_decoder_multi_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) ();
  logic [NUM_CH-1:0]       rot_a;
  logic [NUM_CH-1:0]       rot_b;
  logic [NUM_CH-1:0]       pos_clr;
  logic [NUM_CH-1:0]       step_r;
  logic [NUM_CH-1:0]       step_l;
  logic [NUM_CH-1:0]       err;
  logic [NUM_CH*CNT_W-1:0] pos;

  modport master (
    output rot_a, rot_b, pos_clr,
    input  step_r, step_l, err, pos
  );

  modport slave (
    input  rot_a, rot_b, pos_clr,
    output step_r, step_l, err, pos
  );
endinterface

// File: rtl/quad_decoder_multi.sv
// Multi-channel rotary encoder decoder: per-pin synchroniser and debounce, Gray-code
// decode into registered step/err pulses and a wrapping signed position count.
module quad_decoder_multi #(
  parameter int NUM_CH       = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = 8,
  parameter int MODE         = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  quad_decoder_multi_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Line index 1 is A, index 0 is B, so {a,b} reads naturally as a 2-bit state.
    logic [1:0]                  w_raw;
    logic [1:0]                  w_sync_out;
    logic [1:0][SYNC_STAGES-1:0] r_sync;
    logic [1:0][DB_W-1:0]        r_cnt;
    logic [1:0]                  r_filt;
    logic [1:0]                  r_prev;
    logic                        r_step_r;
    logic                        r_step_l;
    logic                        r_err;
    logic [CNT_W-1:0]            r_pos;

    logic [1:0] w_chg;
    logic       w_valid;
    logic       w_both;
    logic       w_cw;
    logic       w_gate;
    logic       w_count;

    assign w_raw      = {bus.rot_a[g], bus.rot_b[g]};
    assign w_sync_out = {r_sync[1][SYNC_STAGES-1], r_sync[0][SYNC_STAGES-1]};

    // Walking the CW table 11->01->00->10->11: an A change is CW when A!=B afterwards,
    // a B change is CW when A==B afterwards.
    assign w_chg   = r_filt ^ r_prev;
    assign w_valid = w_chg[1] ^ w_chg[0];
    assign w_both  = w_chg[1] & w_chg[0];
    assign w_cw    = w_chg[1] ? (r_filt[1] ^ r_filt[0]) : ~(r_filt[1] ^ r_filt[0]);
    assign w_gate  = (MODE == 4) ? 1'b1 :
                     (MODE == 2) ? w_chg[1] :
                                   (w_chg[1] & r_filt[1]);
    assign w_count = w_valid & w_gate;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync   <= '1;
        r_cnt    <= '0;
        r_filt   <= 2'b11;
        r_prev   <= 2'b11;
        r_step_r <= 1'b0;
        r_step_l <= 1'b0;
        r_err    <= 1'b0;
        r_pos    <= '0;
      end else begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values,
        // so the sync chain shifts one stage per clock regardless of statement order.
        for (int l = 0; l < 2; l++) begin
          r_sync[l] <= {r_sync[l][SYNC_STAGES-2:0], w_raw[l]};
          if (w_sync_out[l] == r_filt[l]) begin
            r_cnt[l] <= '0;
          end else if (r_cnt[l] == DB_W'(DEBOUNCE_CYC - 1)) begin
            r_filt[l] <= w_sync_out[l];
            r_cnt[l]  <= '0;
          end else begin
            r_cnt[l] <= r_cnt[l] + DB_W'(1);
          end
        end

        // prev always follows filtered, so ungated and illegal transitions resync silently
        r_prev   <= r_filt;
        r_step_r <= w_count & w_cw;
        r_step_l <= w_count & ~w_cw;
        r_err    <= w_both;

        if (bus.pos_clr[g])
          r_pos <= '0;
        else if (w_count && w_cw)
          r_pos <= r_pos + CNT_W'(1);
        else if (w_count)
          r_pos <= r_pos - CNT_W'(1);
      end
    end

    assign bus.step_r[g]                = r_step_r;
    assign bus.step_l[g]                = r_step_l;
    assign bus.err[g]                   = r_err;
    assign bus.pos[g*CNT_W +: CNT_W]    = r_pos;
  end

endmodule

// File: tb/tb_quad_decoder_multi.sv
// Directed bench: three decoder instances (MODE 4, 1, 2) share the same pin stimulus so
// each scenario shows how resolution changes the step/pos result.
module tb_quad_decoder_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int HOLD   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH-1:0] pin_a = '1;
  logic [NUM_CH-1:0] pin_b = '1;
  logic [NUM_CH-1:0] clr   = '0;

  int checks = 0;
  int errors = 0;

  // instance index: 0 = MODE 4, 1 = MODE 1, 2 = MODE 2
  int nr[3][NUM_CH];
  int nl[3][NUM_CH];
  int ne[3][NUM_CH];

  always #5 clk = ~clk;

  quad_decoder_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) if4 ();
  quad_decoder_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) if1 ();
  quad_decoder_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) if2 ();

  assign if4.rot_a = pin_a;  assign if4.rot_b = pin_b;  assign if4.pos_clr = clr;
  assign if1.rot_a = pin_a;  assign if1.rot_b = pin_b;  assign if1.pos_clr = clr;
  assign if2.rot_a = pin_a;  assign if2.rot_b = pin_b;  assign if2.pos_clr = clr;

  quad_decoder_multi #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .DEBOUNCE_CYC(16), .CNT_W(CNT_W), .MODE(4))
    u_m4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  quad_decoder_multi #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .DEBOUNCE_CYC(16), .CNT_W(CNT_W), .MODE(1))
    u_m1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  quad_decoder_multi #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .DEBOUNCE_CYC(16), .CNT_W(CNT_W), .MODE(2))
    u_m2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // Pulse counters sample at the rising edge, i.e. the value held through the previous cycle.
  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (if4.step_r[c]) nr[0][c]++;
      if (if4.step_l[c]) nl[0][c]++;
      if (if4.err[c])    ne[0][c]++;
      if (if1.step_r[c]) nr[1][c]++;
      if (if1.step_l[c]) nl[1][c]++;
      if (if1.err[c])    ne[1][c]++;
      if (if2.step_r[c]) nr[2][c]++;
      if (if2.step_l[c]) nl[2][c]++;
      if (if2.err[c])    ne[2][c]++;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < NUM_CH; c++) begin
        nr[i][c] = 0;
        nl[i][c] = 0;
        ne[i][c] = 0;
      end
  endtask

  task automatic set_ch0(input logic a_v, input logic b_v, input int hold);
    pin_a[0] = a_v;
    pin_b[0] = b_v;
    wait_n(hold);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pin_a = NUM_CH'($urandom);
      pin_b = NUM_CH'($urandom);
      wait_n(1);
    end
    checks++;
    if ({if4.step_r, if4.step_l, if4.err, if4.pos} !== '0) begin
      errors++;
      $display("FAIL reset_m4 outputs got %0h want 0", {if4.step_r, if4.step_l, if4.err, if4.pos});
    end
    checks++;
    if ({if1.step_r, if1.step_l, if1.err, if1.pos, if2.step_r, if2.step_l, if2.err, if2.pos} !== '0) begin
      errors++;
      $display("FAIL reset_m1m2 outputs not zero");
    end
    pin_a = '1;
    pin_b = '1;
    wait_n(3);
    rst_n = 1'b1;
    clear_counts();
    wait_n(40);
    checks++;
    if (nr[0][0] + nl[0][0] + ne[0][0] + nr[0][1] + nl[0][1] + ne[0][1] != 0) begin
      errors++;
      $display("FAIL reset_release_pulses got %0d want 0",
               nr[0][0] + nl[0][0] + ne[0][0] + nr[0][1] + nl[0][1] + ne[0][1]);
    end
    checks++;
    if (if4.pos !== '0) begin
      errors++;
      $display("FAIL reset_release_pos got %0h want 0", if4.pos);
    end
  endtask

  task automatic test_cw_ccw();
    clear_counts();
    // first change 11->01, check exact 19-edge latency
    pin_a[0] = 1'b0;
    wait_n(18);
    checks++;
    if (if4.step_r[0] !== 1'b0) begin
      errors++;
      $display("FAIL latency_early step_r got %b want 0", if4.step_r[0]);
    end
    wait_n(1);
    checks++;
    if (if4.step_r[0] !== 1'b1) begin
      errors++;
      $display("FAIL latency_19 step_r got %b want 1", if4.step_r[0]);
    end
    wait_n(HOLD - 19);
    set_ch0(1'b0, 1'b0, HOLD);
    set_ch0(1'b1, 1'b0, HOLD);
    set_ch0(1'b1, 1'b1, HOLD + 2);
    checks++;
    if (nr[0][0] != 4 || nl[0][0] != 0 || if4.pos[7:0] !== 8'd4) begin
      errors++;
      $display("FAIL cw_m4 r=%0d l=%0d pos=%0h want r=4 l=0 pos=04", nr[0][0], nl[0][0], if4.pos[7:0]);
    end
    checks++;
    if (nr[1][0] != 1 || nl[1][0] != 0 || if1.pos[7:0] !== 8'd1) begin
      errors++;
      $display("FAIL cw_m1 r=%0d l=%0d pos=%0h want r=1 l=0 pos=01", nr[1][0], nl[1][0], if1.pos[7:0]);
    end
    checks++;
    if (nr[2][0] != 2 || nl[2][0] != 0 || if2.pos[7:0] !== 8'd2) begin
      errors++;
      $display("FAIL cw_m2 r=%0d l=%0d pos=%0h want r=2 l=0 pos=02", nr[2][0], nl[2][0], if2.pos[7:0]);
    end

    clear_counts();
    set_ch0(1'b1, 1'b0, HOLD);
    set_ch0(1'b0, 1'b0, HOLD);
    set_ch0(1'b0, 1'b1, HOLD);
    set_ch0(1'b1, 1'b1, HOLD + 2);
    checks++;
    if (nl[0][0] != 4 || nr[0][0] != 0 || if4.pos[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL ccw_m4 l=%0d r=%0d pos=%0h want l=4 r=0 pos=00", nl[0][0], nr[0][0], if4.pos[7:0]);
    end
    checks++;
    if (nl[1][0] != 1 || if1.pos[7:0] !== 8'd0 || nl[2][0] != 2 || if2.pos[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL ccw_m1m2 l1=%0d pos1=%0h l2=%0d pos2=%0h want 1 00 2 00",
               nl[1][0], if1.pos[7:0], nl[2][0], if2.pos[7:0]);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    set_ch0(1'b0, 1'b1, 10);
    set_ch0(1'b1, 1'b1, 40);
    checks++;
    if (nr[0][0] + nl[0][0] + ne[0][0] != 0 || if4.pos[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL glitch_short pulses=%0d pos=%0h want 0 00",
               nr[0][0] + nl[0][0] + ne[0][0], if4.pos[7:0]);
    end
    set_ch0(1'b0, 1'b1, 16);
    set_ch0(1'b1, 1'b1, 40);
    checks++;
    if (nr[0][0] != 1 || nl[0][0] != 1) begin
      errors++;
      $display("FAIL glitch_16_m4 r=%0d l=%0d want 1 1", nr[0][0], nl[0][0]);
    end
    checks++;
    if (nr[1][0] != 0 || nl[1][0] != 1) begin
      errors++;
      $display("FAIL glitch_16_m1 r=%0d l=%0d want 0 1", nr[1][0], nl[1][0]);
    end
  endtask

  task automatic test_both_change();
    clear_counts();
    set_ch0(1'b0, 1'b0, 40);
    checks++;
    if (ne[0][0] != 1 || nr[0][0] + nl[0][0] != 0 || if4.pos[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL both_err err=%0d steps=%0d pos=%0h want 1 0 00",
               ne[0][0], nr[0][0] + nl[0][0], if4.pos[7:0]);
    end
    set_ch0(1'b1, 1'b1, 40);
    checks++;
    if (ne[0][0] != 2 || ne[1][0] != 2 || nr[0][0] + nl[0][0] != 0) begin
      errors++;
      $display("FAIL both_back err4=%0d err1=%0d steps=%0d want 2 2 0",
               ne[0][0], ne[1][0], nr[0][0] + nl[0][0]);
    end
  endtask

  task automatic test_wrap_and_clear();
    logic [1:0] cw_seq [4];
    logic [1:0] ccw_seq [4];
    cw_seq  = '{2'b01, 2'b00, 2'b10, 2'b11};
    ccw_seq = '{2'b10, 2'b00, 2'b01, 2'b11};
    clr = '1;
    wait_n(1);
    clr = '0;
    wait_n(2);
    for (int k = 0; k < 32; k++) begin
      for (int s = 0; s < 4; s++) begin
        {pin_a[0], pin_b[0]} = cw_seq[s];
        {pin_a[1], pin_b[1]} = (k < 8) ? ccw_seq[s] : 2'b11;
        wait_n(HOLD);
      end
    end
    wait_n(2);
    checks++;
    if (if4.pos[7:0] !== 8'h80 || if4.pos[15:8] !== 8'hE0) begin
      errors++;
      $display("FAIL wrap_m4 pos0=%0h pos1=%0h want 80 e0", if4.pos[7:0], if4.pos[15:8]);
    end
    checks++;
    if (if1.pos[7:0] !== 8'h20 || if1.pos[15:8] !== 8'hF8) begin
      errors++;
      $display("FAIL wrap_m1 pos0=%0h pos1=%0h want 20 f8", if1.pos[7:0], if1.pos[15:8]);
    end
    checks++;
    if (if2.pos[7:0] !== 8'h40 || if2.pos[15:8] !== 8'hF0) begin
      errors++;
      $display("FAIL wrap_m2 pos0=%0h pos1=%0h want 40 f0", if2.pos[7:0], if2.pos[15:8]);
    end

    // pos_clr on the exact edge that registers the step
    pin_a[0] = 1'b0;
    wait_n(18);
    clr = 2'b01;
    wait_n(1);
    checks++;
    if (if4.step_r[0] !== 1'b1 || if4.pos[7:0] !== 8'h00) begin
      errors++;
      $display("FAIL clr_coincident step_r=%b pos0=%0h want 1 00", if4.step_r[0], if4.pos[7:0]);
    end
    clr = '0;
    wait_n(HOLD);
    checks++;
    if (if4.pos[7:0] !== 8'h00 || if4.pos[15:8] !== 8'hE0) begin
      errors++;
      $display("FAIL clr_hold pos0=%0h pos1=%0h want 00 e0", if4.pos[7:0], if4.pos[15:8]);
    end
    set_ch0(1'b1, 1'b1, HOLD + 2);
    checks++;
    if (if4.pos[7:0] !== 8'hFF) begin
      errors++;
      $display("FAIL underflow pos0=%0h want ff", if4.pos[7:0]);
    end
  endtask

  task automatic test_reset_mid_rotation();
    clear_counts();
    set_ch0(1'b0, 1'b1, 10);
    rst_n = 1'b0;
    wait_n(3);
    checks++;
    if (if4.pos[7:0] !== 8'h00) begin
      errors++;
      $display("FAIL midrot_reset pos0=%0h want 00", if4.pos[7:0]);
    end
    rst_n = 1'b1;
    clear_counts();
    wait_n(40);
    checks++;
    if (nr[0][0] != 1 || nl[0][0] != 0 || if4.pos[7:0] !== 8'h01) begin
      errors++;
      $display("FAIL midrot_decode r=%0d l=%0d pos0=%0h want 1 0 01", nr[0][0], nl[0][0], if4.pos[7:0]);
    end
    set_ch0(1'b1, 1'b1, 40);
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_cw_ccw();
    test_glitch();
    test_both_change();
    test_wrap_and_clear();
    test_reset_mid_rotation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
